// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access controller: FSM encoding,
// default bus widths and the byte-lane mask.
// Pure declarations, no logic.
package mem_access_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;

  localparam logic [31:0] BYTE_MASK = 32'h000000FF;

endpackage

// File: rtl/mem_access_ctrl_load_format.sv
// Load-result formatting: passes words through, extends byte loads, zeroes stores.
// Latency: combinational.
// Backpressure: none; the caller decides when the result is captured.
// MEM_ACCESS_SIGN_EXT_EN defined: byte loads sign-extend. Undefined: zero-extend.
module mem_load_format
  import mem_access_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              byte_op,
  input  logic              is_write,
  input  logic [DATA_W-1:0] raw_data,
  output logic [DATA_W-1:0] fmt_data
);

  // Stores report zero; loads select word or extended low byte
  always_comb begin
    fmt_data = '0;
    if (!is_write) begin
      if (byte_op) begin
`ifdef MEM_ACCESS_SIGN_EXT_EN
        fmt_data = {{(DATA_W-8){raw_data[7]}}, raw_data[7:0]};
`else
        fmt_data = raw_data & DATA_W'(BYTE_MASK);
`endif
      end else begin
        fmt_data = raw_data;
      end
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator side of the data-memory port: one load/store at a time, strobes held MEM_LATENCY cycles.
// Latency: accept edge N, strobes N+1..N+MEM_LATENCY, resp_valid pulse in cycle N+MEM_LATENCY+1.
// Backpressure: req_ready high only in IDLE; requests seen while busy are dropped, not queued.
// MEM_ACCESS_SIGN_EXT_EN selects sign-extended byte loads (default: zero-extended).
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_byte,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_byte_op
);

  // Counter counts down to zero so the final ACCESS cycle is the one with cnt==0.
  localparam logic [3:0] LAT_LOAD = 4'(MEM_LATENCY - 1);

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic              lat_write;
  logic [DATA_W-1:0] load_fmt;

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);

  mem_load_format #(
    .DATA_W (DATA_W)
  ) u_load_format (
    .byte_op  (mem_byte_op),
    .is_write (lat_write),
    .raw_data (mem_read_data),
    .fmt_data (load_fmt)
  );

  // FSM, latency counter, latched request driving the memory port, and response capture
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      cnt            <= 4'd0;
      lat_write      <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      mem_byte_op    <= 1'b0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      resp_rdata     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            state       <= ST_ACCESS;
            cnt         <= LAT_LOAD;
            lat_write   <= req_write;
            mem_address <= req_addr;
            mem_byte_op <= req_byte;
            mem_read    <= !req_write;
            mem_write   <= req_write;
            // Only the low byte lane is meaningful for byte stores; loads drive no data.
            if (!req_write)
              mem_write_data <= '0;
            else if (req_byte)
              mem_write_data <= req_wdata & DATA_W'(BYTE_MASK);
            else
              mem_write_data <= req_wdata;
          end
        end
        ST_ACCESS: begin
          if (cnt == 4'd0) begin
            state      <= ST_RESP;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            resp_rdata <= load_fmt;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl with a behavioural byte memory attached.
// Driver pushes expected results into a queue; a negedge monitor checks the memory port and responses.
// Stimulus: directed scenarios followed by randomized loads/stores.
module tb_mem_access_ctrl;

  localparam int L = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic        req_byte = 1'b0;
  logic [7:0]  req_addr = 8'h00;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [7:0]  mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        mem_read;
  logic        mem_write;
  logic        mem_byte_op;

  mem_access_ctrl #(.ADDR_W(8), .DATA_W(32), .MEM_LATENCY(L)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_byte       (req_byte),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_byte_op    (mem_byte_op)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 151 + 59) ^ (i >> 3));
  endfunction

  // Behavioural stand-in for Memory_block: little-endian bytes, writes on strobed edges.
  logic [7:0] env_mem [256];
  assign mem_read_data = {env_mem[mem_address + 8'd3], env_mem[mem_address + 8'd2],
                          env_mem[mem_address + 8'd1], env_mem[mem_address]};
  initial begin
    for (int i = 0; i < 256; i++) env_mem[i] = init_byte(i);
    forever begin
      @(posedge clk);
      if (mem_write && !reset) begin
        if (mem_byte_op) env_mem[mem_address] = mem_write_data[7:0];
        else for (int k = 0; k < 4; k++) env_mem[mem_address + 8'(k)] = mem_write_data[8*k +: 8];
      end
    end
  end

  // Reference model state
  typedef struct {
    logic        wr;
    logic        bt;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          acc;
  } exp_t;

  exp_t       q[$];
  logic [7:0] ref_mem [256];
  int         resp_cnt = 0;
  int         run = 0;

  task automatic push_exp(input logic w, input logic b, input logic [7:0] a, input logic [31:0] d);
    exp_t e;
    e.wr = w; e.bt = b; e.addr = a; e.acc = cyc + 1;
    e.wdata = !w ? 32'h0 : (b ? {24'h0, d[7:0]} : d);
    e.rdata = 32'h0;
    if (w) begin
      if (b) ref_mem[a] = d[7:0];
      else for (int k = 0; k < 4; k++) ref_mem[a + 8'(k)] = d[8*k +: 8];
    end else if (b) begin
`ifdef MEM_ACCESS_SIGN_EXT_EN
      e.rdata = {{24{ref_mem[a][7]}}, ref_mem[a]};
`else
      e.rdata = {24'h0, ref_mem[a]};
`endif
    end else begin
      e.rdata = {ref_mem[a + 8'd3], ref_mem[a + 8'd2], ref_mem[a + 8'd1], ref_mem[a]};
    end
    q.push_back(e);
  endtask

  // Monitor: memory-port fields, strobe window length, response data and timing
  always @(negedge clk) begin
    if (reset) begin
      run = 0;
    end else begin
      if (mem_read && mem_write) chk("strobes_exclusive", 32'(mem_read & mem_write), 32'h0);
      if (mem_read || mem_write) begin
        if (q.size() == 0) begin
          chk("unexpected_strobe", 32'(mem_read | mem_write), 32'h0);
        end else if (run == 0) begin
          chk("mem_address", 32'(mem_address), 32'(q[0].addr));
          chk("mem_write_data", mem_write_data, q[0].wdata);
          chk("mem_byte_op", 32'(mem_byte_op), 32'(q[0].bt));
          chk("mem_write", 32'(mem_write), 32'(q[0].wr));
          chk("mem_read", 32'(mem_read), 32'(!q[0].wr));
          chk("strobe_start_cycle", 32'(cyc), 32'(q[0].acc));
        end else if (mem_address !== q[0].addr || mem_write_data !== q[0].wdata) begin
          chk("mem_port_stable", mem_write_data, q[0].wdata);
        end
        run++;
      end else if (run != 0) begin
        chk("strobe_len", 32'(run), 32'(L));
        run = 0;
      end
      if (resp_valid) begin
        resp_cnt++;
        if (q.size() == 0) begin
          chk("unexpected_resp", 32'(resp_valid), 32'h0);
        end else begin
          chk("resp_rdata", resp_rdata, q[0].rdata);
          chk("resp_cycle", 32'(cyc), 32'(q[0].acc + L));
          chk("ready_low_in_resp", 32'(req_ready), 32'h0);
          void'(q.pop_front());
        end
      end
    end
  end

  // Present a request until accepted, then optionally hold garbage while busy
  task automatic do_req(input logic w, input logic b, input logic [7:0] a, input logic [31:0] d,
                        input int hold);
    int waited;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_byte = b; req_addr = a; req_wdata = d;
    waited = 0;
    while (!req_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'(req_ready), 32'h1);
      req_valid = 1'b0;
      return;
    end
    push_exp(w, b, a, d);
    @(negedge clk);
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_write = 1'($urandom_range(0, 1));
      req_addr  = 8'($urandom);
      req_wdata = $urandom;
      @(negedge clk);
    end
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (q.size() != 0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    chk("drain_empty", 32'(q.size()), 32'h0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc0;
    int acc_n;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'h1);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_strobes", {30'h0, mem_read, mem_write}, 32'h0);
    chk("rst_byte_op", 32'(mem_byte_op), 32'h0);
    chk("rst_mem_address", 32'(mem_address), 32'h0);
    chk("rst_mem_write_data", mem_write_data, 32'h0);
    reset = 1'b0;

    // Directed: word store/load, byte store/load, sign extension, top address
    do_req(1'b1, 1'b0, 8'h00, 32'h10000002, 0);
    do_req(1'b0, 1'b0, 8'h00, 32'h0, 0);
    do_req(1'b1, 1'b1, 8'h01, 32'hDEADBE77, 0);
    do_req(1'b0, 1'b1, 8'h01, 32'h0, 0);
    do_req(1'b1, 1'b1, 8'h02, 32'h12345680, 1);
    do_req(1'b0, 1'b1, 8'h02, 32'h0, 0);
    do_req(1'b0, 1'b0, 8'h00, 32'h0, L);
    do_req(1'b1, 1'b0, 8'hFF, 32'hCAFEF00D, 0);
    do_req(1'b0, 1'b0, 8'hFF, 32'h0, 0);
    do_req(1'b0, 1'b1, 8'hFF, 32'h0, 0);
    drain();

    // req_valid held high for 10 cycles: three accepts, three responses
    rc0 = resp_cnt;
    acc_n = 0;
    for (int i = 0; i < 10; i++) begin
      req_valid = 1'b1; req_write = 1'b0; req_byte = 1'b0; req_addr = 8'h00; req_wdata = 32'h0;
      if (req_ready) begin
        push_exp(1'b0, 1'b0, 8'h00, 32'h0);
        acc_n++;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    drain();
    chk("b2b_accepts", 32'(acc_n), 32'd3);
    chk("b2b_resp_pulses", 32'(resp_cnt - rc0), 32'd3);

    // Reset during the second ACCESS cycle of a load aborts it without a response
    rc0 = resp_cnt;
    do_req(1'b0, 1'b0, 8'h10, 32'h0, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    q.delete();
    chk("abort_strobes", {30'h0, mem_read, mem_write}, 32'h0);
    chk("abort_ready", 32'(req_ready), 32'h1);
    chk("abort_no_resp", 32'(resp_valid), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_resp_count", 32'(resp_cnt - rc0), 32'h0);
    do_req(1'b0, 1'b0, 8'h10, 32'h0, 0);
    drain();

    // Reset together with req_valid: request is not accepted
    @(negedge clk);
    reset = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h20;
    @(negedge clk);
    chk("rst_vs_req_strobe", 32'(mem_read), 32'h0);
    chk("rst_vs_req_ready", 32'(req_ready), 32'h1);
    reset = 1'b0; req_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_vs_req_idle", {30'h0, mem_read, mem_write}, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      do_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             (i % 10 == 0) ? 8'hFF : 8'($urandom), $urandom, int'($urandom_range(0, L)));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
